// File: rtl/dr_pkg.sv
// Shared types for the data-router family: reg_array lane commands, buffer
// read modes and the window_sequencer state encoding.
package dr_pkg;

    typedef enum logic [1:0] {
        IB   = 2'b00,   // load from input buffer
        SF   = 2'b01,   // shift
        IF   = 2'b10,   // load from recirculation FIFO
        HOLD = 2'b11
    } rcmd_e;

    typedef enum logic [1:0] {
        RR = 2'b00,     // all rows
        BR = 2'b01,     // one bank row
        RP = 2'b10,     // single pixel
        NE = 2'b11      // no read
    } rpsel_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        LOAD,
        SHIFT,
        DONE
    } wseq_state_e;

    // Out-of-range strides fall back to 1 so the address walk stays defined.
    function automatic logic [1:0] norm_stride(input logic [1:0] s, input int str_max);
        if (s == 2'd0 || int'(s) > str_max) begin
            return 2'd1;
        end
        return s;
    endfunction

endpackage

// File: rtl/wseq_addr_gen.sv
// Buffer address counters for window_sequencer: column, bank, row and the
// base row of the current POY-row group.
module wseq_addr_gen
    import dr_pkg::*;
#(
    parameter int POY   = 3,
    parameter int ROW_W = 8,
    parameter int COL_W = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic             col_step,
    input  logic             grp_step,
    input  logic [1:0]       stride,
    output logic [COL_W-1:0] col,
    output logic [7:0]       bank,
    output logic [ROW_W-1:0] row
);

    localparam logic [7:0] BANK_LAST = 8'(POY - 1);

    logic [ROW_W-1:0] group_base;
    logic [ROW_W-1:0] grp_inc;
    logic [ROW_W-1:0] next_base;

    assign grp_inc   = ROW_W'(POY * int'(stride));
    assign next_base = group_base + grp_inc;

    // Counter update: block start clears, group step rebases, column step walks banks.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || init) begin
            col        <= '0;
            bank       <= BANK_LAST;
            row        <= '0;
            group_base <= '0;
        end else if (grp_step) begin
            col        <= '0;
            bank       <= BANK_LAST;
            row        <= next_base;
            group_base <= next_base;
        end else if (col_step) begin
            col <= col + COL_W'(stride);
            if (bank == BANK_LAST) begin
                bank <= '0;
                row  <= row + ROW_W'(1);
            end else begin
                bank <= bank + 8'd1;
            end
        end
    end

endmodule

// File: rtl/window_sequencer.sv
// Depthwise window sequencer: walks one output block column by column and
// row-group by row-group, issuing buffer reads, reg_array lane commands,
// FIFO pops and a valid/ready beat stream to dwpe.
module window_sequencer
    import dr_pkg::*;
#(
    parameter int KSIZE   = 3,
    parameter int POY     = 3,
    parameter int STR_MAX = 2,
    parameter int ROW_W   = 8,
    parameter int COL_W   = 28,
    parameter int DIM_W   = 8,
    parameter int RD_LAT  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               blk_start,
    input  logic [1:0]         cfg_stride,
    input  logic [DIM_W-1:0]   cfg_ow,
    input  logic [DIM_W-1:0]   cfg_ohg,
    output logic               rd_req,
    output logic [1:0]         rd_sel,
    output logic [7:0]         rd_bank,
    output logic [ROW_W-1:0]   rd_row,
    output logic [COL_W-1:0]   rd_col,
    output logic [2*POY-1:0]   reg_array_cmd,
    output logic               fifo_read,
    output logic               dwpe_valid,
    input  logic               dwpe_ready,
    output logic               busy,
    output logic               blk_done
);

    localparam int               CNT_W      = 8;
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RD_LAT - 2);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(KSIZE - 2);

    wseq_state_e      state, state_nxt;
    logic [1:0]       stride_q;
    logic [DIM_W-1:0] ow_q, ohg_q, col_idx, grp_idx;
    logic [CNT_W-1:0] wait_cnt, shift_cnt;
    logic             load_fresh;
    logic             first_col, last_col, last_grp;
    logic             beat_state, accept, init;
    logic             col_step, grp_step;
    rpsel_e           sel;

    assign first_col  = (col_idx == '0);
    assign last_col   = (col_idx == ow_q - DIM_W'(1));
    assign last_grp   = (grp_idx == ohg_q - DIM_W'(1));
    assign beat_state = (state == LOAD) || (state == SHIFT);
    assign dwpe_valid = beat_state;
    assign accept     = beat_state && dwpe_ready;
    assign init       = (state == IDLE) && blk_start;
    assign rd_sel     = sel;

    wseq_addr_gen #(
        .POY   (POY),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .init     (init),
        .col_step (col_step),
        .grp_step (grp_step),
        .stride   (stride_q),
        .col      (rd_col),
        .bank     (rd_bank),
        .row      (rd_row)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Block configuration, walk indices and the per-state cycle/beat counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stride_q   <= 2'd1;
            ow_q       <= '0;
            ohg_q      <= '0;
            col_idx    <= '0;
            grp_idx    <= '0;
            wait_cnt   <= '0;
            shift_cnt  <= '0;
            load_fresh <= 1'b0;
        end else begin
            // Marks the first LOAD cycle so a stalled LOAD does not pop the FIFO twice.
            load_fresh <= (state == WAIT) && (state_nxt == LOAD);
            if (init) begin
                stride_q <= norm_stride(cfg_stride, STR_MAX);
                ow_q     <= cfg_ow;
                ohg_q    <= cfg_ohg;
                col_idx  <= '0;
                grp_idx  <= '0;
            end
            if (state == WAIT) begin
                wait_cnt <= (wait_cnt == WAIT_LAST) ? '0 : wait_cnt + CNT_W'(1);
            end
            if (state == SHIFT && accept) begin
                shift_cnt <= (shift_cnt == SHIFT_LAST) ? '0 : shift_cnt + CNT_W'(1);
            end
            if (col_step) begin
                col_idx <= col_idx + DIM_W'(1);
            end
            if (grp_step) begin
                col_idx <= '0;
                grp_idx <= grp_idx + DIM_W'(1);
            end
        end
    end

    // Next state and outputs; a stalled beat drives HOLD and freezes the walk.
    // NOTE: every combinational output is defaulted first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        sel       = NE;
        fifo_read = 1'b0;
        busy      = (state != IDLE);
        blk_done  = 1'b0;
        col_step  = 1'b0;
        grp_step  = 1'b0;
        for (int i = 0; i < POY; i++) begin
            reg_array_cmd[2*i +: 2] = HOLD;
        end

        case (state)
            IDLE: begin
                if (blk_start) begin
                    state_nxt = (cfg_ow == '0 || cfg_ohg == '0) ? DONE : RD;
                end
            end
            RD: begin
                rd_req    = 1'b1;
                sel       = first_col ? RR : BR;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                fifo_read = load_fresh && !first_col;
                if (dwpe_ready) begin
                    for (int i = 0; i < POY; i++) begin
                        reg_array_cmd[2*i +: 2] = (!first_col && i < POY - 1) ? IF : IB;
                    end
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (dwpe_ready) begin
                    for (int i = 0; i < POY; i++) begin
                        reg_array_cmd[2*i +: 2] = SF;
                    end
                    if (shift_cnt == SHIFT_LAST) begin
                        if (!last_col) begin
                            col_step  = 1'b1;
                            state_nxt = RD;
                        end else if (!last_grp) begin
                            grp_step  = 1'b1;
                            state_nxt = RD;
                        end else begin
                            state_nxt = DONE;
                        end
                    end
                end
            end
            DONE: begin
                blk_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_window_sequencer.sv
// Bench for window_sequencer. Instance a uses KSIZE=3/POY=3, instance b uses
// KSIZE=5/POY=4. A closed-form model queues the expected reads and beats per
// block; a negedge monitor pops and compares as the DUT presents them.
`timescale 1ns/1ps
module tb_window_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a
    logic        rst_n_a, blk_start_a, dwpe_ready_a;
    logic [1:0]  cfg_stride_a;
    logic [7:0]  cfg_ow_a, cfg_ohg_a;
    logic        rd_req_a, fifo_a, valid_a, busy_a, done_a;
    logic [1:0]  rd_sel_a;
    logic [7:0]  rd_bank_a, rd_row_a;
    logic [27:0] rd_col_a;
    logic [5:0]  cmd_a;

    // Instance b
    logic        rst_n_b, blk_start_b, dwpe_ready_b;
    logic [1:0]  cfg_stride_b;
    logic [7:0]  cfg_ow_b, cfg_ohg_b;
    logic        rd_req_b, fifo_b, valid_b, busy_b, done_b;
    logic [1:0]  rd_sel_b;
    logic [7:0]  rd_bank_b, rd_row_b;
    logic [27:0] rd_col_b;
    logic [7:0]  cmd_b;

    window_sequencer #(.KSIZE(3), .POY(3), .STR_MAX(2), .RD_LAT(3)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .blk_start(blk_start_a), .cfg_stride(cfg_stride_a),
        .cfg_ow(cfg_ow_a), .cfg_ohg(cfg_ohg_a), .rd_req(rd_req_a), .rd_sel(rd_sel_a),
        .rd_bank(rd_bank_a), .rd_row(rd_row_a), .rd_col(rd_col_a), .reg_array_cmd(cmd_a),
        .fifo_read(fifo_a), .dwpe_valid(valid_a), .dwpe_ready(dwpe_ready_a),
        .busy(busy_a), .blk_done(done_a)
    );

    window_sequencer #(.KSIZE(5), .POY(4), .STR_MAX(3), .RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .blk_start(blk_start_b), .cfg_stride(cfg_stride_b),
        .cfg_ow(cfg_ow_b), .cfg_ohg(cfg_ohg_b), .rd_req(rd_req_b), .rd_sel(rd_sel_b),
        .rd_bank(rd_bank_b), .rd_row(rd_row_b), .rd_col(rd_col_b), .reg_array_cmd(cmd_b),
        .fifo_read(fifo_b), .dwpe_valid(valid_b), .dwpe_ready(dwpe_ready_b),
        .busy(busy_b), .blk_done(done_b)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [7:0]  bank;
        logic [7:0]  row;
        logic [27:0] col;
    } rd_t;

    typedef struct {
        logic [7:0] cmd;
        int         fifo;
    } beat_t;

    rd_t   rdq_a[$], rdq_b[$];
    beat_t bq_a[$], bq_b[$];
    rd_t   mon_r;
    beat_t mon_b;

    int n_cmp = 0;
    int n_bad = 0;
    int reads_a = 0, reads_b = 0, beats_a = 0, beats_b = 0;
    int fifos_a = 0, holds_a = 0, dones_a = 0, dones_b = 0;
    int fifo_pend_a = 0, fifo_pend_b = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: column c of group g reads bank (POY-1+c)%POY at row
    // base+(POY-1+c)/POY, column c*stride; beats are one load then KSIZE-1 shifts.
    // Lane encoding: IB=0, SF=1, IF=2, HOLD=3; lane i sits at bits [2i+1:2i].
    task automatic model_block(input int inst, input int stride_in, input int ow, input int ohg);
        int    k, p, smax, s, base;
        rd_t   r;
        beat_t b;
        k    = (inst == 0) ? 3 : 5;
        p    = (inst == 0) ? 3 : 4;
        smax = (inst == 0) ? 2 : 3;
        s    = (stride_in < 1 || stride_in > smax) ? 1 : stride_in;
        for (int g = 0; g < ohg; g++) begin
            base = g * p * s;
            for (int c = 0; c < ow; c++) begin
                r.sel  = (c == 0) ? 2'd0 : 2'd1;
                r.bank = 8'((p - 1 + c) % p);
                r.row  = 8'(base + (p - 1 + c) / p);
                r.col  = 28'(c * s);
                if (inst == 0) rdq_a.push_back(r); else rdq_b.push_back(r);
                b.cmd = '0;
                for (int l = 0; l < p; l++) b.cmd[2*l +: 2] = (c != 0 && l < p - 1) ? 2'd2 : 2'd0;
                b.fifo = (c != 0) ? 1 : 0;
                if (inst == 0) bq_a.push_back(b); else bq_b.push_back(b);
                for (int t = 1; t < k; t++) begin
                    b.cmd = '0;
                    for (int l = 0; l < p; l++) b.cmd[2*l +: 2] = 2'd1;
                    b.fifo = 0;
                    if (inst == 0) bq_a.push_back(b); else bq_b.push_back(b);
                end
            end
        end
    endtask

    // Monitor: pops expected reads/beats whenever the DUT presents one.
    always @(negedge clk) begin
        if (rst_n_a) begin
            if (rd_req_a) begin
                reads_a++;
                if (rdq_a.size() == 0) check("a_rd_unexpected", 1, 0);
                else begin
                    mon_r = rdq_a.pop_front();
                    check("a_rd_sel", rd_sel_a, mon_r.sel);
                    check("a_rd_bank", rd_bank_a, mon_r.bank);
                    check("a_rd_row", rd_row_a, mon_r.row);
                    check("a_rd_col", rd_col_a, mon_r.col);
                end
            end
            if (fifo_a) begin
                fifos_a++;
                fifo_pend_a++;
            end
            if (valid_a && dwpe_ready_a) begin
                beats_a++;
                if (bq_a.size() == 0) check("a_beat_unexpected", 1, 0);
                else begin
                    mon_b = bq_a.pop_front();
                    check("a_cmd", cmd_a, mon_b.cmd);
                    check("a_fifo_per_beat", fifo_pend_a, mon_b.fifo);
                end
                fifo_pend_a = 0;
            end else if (valid_a) begin
                holds_a++;
                check("a_stall_hold", cmd_a, 6'h3f);
            end
            if (done_a) dones_a++;
        end
        if (rst_n_b) begin
            if (rd_req_b) begin
                reads_b++;
                if (rdq_b.size() == 0) check("b_rd_unexpected", 1, 0);
                else begin
                    mon_r = rdq_b.pop_front();
                    check("b_rd_sel", rd_sel_b, mon_r.sel);
                    check("b_rd_bank", rd_bank_b, mon_r.bank);
                    check("b_rd_row", rd_row_b, mon_r.row);
                    check("b_rd_col", rd_col_b, mon_r.col);
                end
            end
            if (fifo_b) fifo_pend_b++;
            if (valid_b && dwpe_ready_b) begin
                beats_b++;
                if (bq_b.size() == 0) check("b_beat_unexpected", 1, 0);
                else begin
                    mon_b = bq_b.pop_front();
                    check("b_cmd", cmd_b, mon_b.cmd);
                    check("b_fifo_per_beat", fifo_pend_b, mon_b.fifo);
                end
                fifo_pend_b = 0;
            end else if (valid_b) begin
                check("b_stall_hold", cmd_b, 8'hff);
            end
            if (done_b) dones_b++;
        end
    end

    task automatic check_reset_a();
        check("rst_rd_req", rd_req_a, 0);
        check("rst_rd_sel", rd_sel_a, 2'd3);
        check("rst_rd_bank", rd_bank_a, 8'd2);
        check("rst_rd_row", rd_row_a, 0);
        check("rst_rd_col", rd_col_a, 0);
        check("rst_cmd", cmd_a, 6'h3f);
        check("rst_fifo", fifo_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
    endtask

    // Runs one block. Latency counts clock edges from the one sampling
    // blk_start to the one sampling blk_done high (T1 -> 14, ow=0 -> 2).
    // rmode 1 randomises dwpe_ready; otherwise ready drops for stall_len
    // cycles from cycle stall_at. restart_at re-pulses blk_start mid-block.
    task automatic run_block(input int inst, input int stride, input int ow, input int ohg,
                             input int rmode, input int stall_at, input int stall_len,
                             input int restart_at, output int lat);
        int  n;
        bit  seen;
        bit  rdy;
        model_block(inst, stride, ow, ohg);
        @(posedge clk); #2;
        if (inst == 0) begin
            blk_start_a = 1'b1; cfg_stride_a = 2'(stride); cfg_ow_a = 8'(ow); cfg_ohg_a = 8'(ohg);
        end else begin
            blk_start_b = 1'b1; cfg_stride_b = 2'(stride); cfg_ow_b = 8'(ow); cfg_ohg_b = 8'(ohg);
        end
        lat  = -1;
        seen = 1'b0;
        n    = 1;
        while (!seen && n <= 2000) begin
            @(posedge clk); #2;
            rdy = (rmode == 1) ? ($urandom % 4 != 0) : !(n >= stall_at && n < stall_at + stall_len);
            if (inst == 0) begin
                blk_start_a  = (n == restart_at);
                dwpe_ready_a = rdy;
                if (n == 1) begin
                    check("a_busy_running", busy_a, 1);
                    cfg_stride_a = 2'($urandom); cfg_ow_a = 8'($urandom); cfg_ohg_a = 8'($urandom);
                end
                if (done_a) seen = 1'b1;
            end else begin
                blk_start_b  = (n == restart_at);
                dwpe_ready_b = rdy;
                if (n == 1) begin
                    check("b_busy_running", busy_b, 1);
                    cfg_stride_b = 2'($urandom); cfg_ow_b = 8'($urandom); cfg_ohg_b = 8'($urandom);
                end
                if (done_b) seen = 1'b1;
            end
            if (seen) lat = n + 1;
            n++;
        end
        if (!seen) check("blk_done_timeout", 0, 1);
        blk_start_a = 1'b0; blk_start_b = 1'b0;
        dwpe_ready_a = 1'b1; dwpe_ready_b = 1'b1;
        @(posedge clk); #2;
        if (inst == 0) begin
            check("a_busy_after", busy_a, 0);
            check("a_rdq_drained", rdq_a.size(), 0);
            check("a_beatq_drained", bq_a.size(), 0);
        end else begin
            check("b_busy_after", busy_b, 0);
            check("b_rdq_drained", rdq_b.size(), 0);
            check("b_beatq_drained", bq_b.size(), 0);
        end
    endtask

    initial begin
        int lat, r0, b0, f0, h0, d0;
        rst_n_a = 0; rst_n_b = 0;
        blk_start_a = 0; blk_start_b = 0;
        cfg_stride_a = 0; cfg_ow_a = 0; cfg_ohg_a = 0;
        cfg_stride_b = 0; cfg_ow_b = 0; cfg_ohg_b = 0;
        dwpe_ready_a = 1; dwpe_ready_b = 1;
        repeat (3) @(posedge clk);
        #2;
        check_reset_a();
        check("b_rst_bank", rd_bank_b, 8'd3);
        check("b_rst_cmd", cmd_b, 8'hff);
        rst_n_a = 1; rst_n_b = 1;

        // T1: stride 1, ow 2, ohg 1, always ready
        r0 = reads_a; b0 = beats_a; f0 = fifos_a; d0 = dones_a;
        run_block(0, 1, 2, 1, 0, 0, 0, 0, lat);
        check("t1_latency", lat, 14);
        check("t1_reads", reads_a - r0, 2);
        check("t1_beats", beats_a - b0, 6);
        check("t1_fifo_pops", fifos_a - f0, 1);
        check("t1_done_pulses", dones_a - d0, 1);

        // T2: stride 2, ow 3, ohg 2, with an ignored blk_start mid-block
        r0 = reads_a;
        run_block(0, 2, 3, 2, 0, 0, 0, 4, lat);
        check("t2_reads", reads_a - r0, 6);

        // T3: T1 with dwpe_ready low for 4 cycles on the 2nd shift beat
        b0 = beats_a; h0 = holds_a;
        run_block(0, 1, 2, 1, 0, 6, 4, 0, lat);
        check("t3_latency", lat, 18);
        check("t3_beats", beats_a - b0, 6);
        check("t3_hold_cycles", holds_a - h0, 4);

        // T4: empty block
        r0 = reads_a; b0 = beats_a; d0 = dones_a;
        run_block(0, 1, 0, 2, 0, 0, 0, 0, lat);
        check("t4_latency", lat, 2);
        check("t4_reads", reads_a - r0, 0);
        check("t4_beats", beats_a - b0, 0);
        check("t4_done_pulses", dones_a - d0, 1);

        // T5: reset mid-shift, then a clean T1
        model_block(0, 1, 2, 1);
        @(posedge clk); #2;
        blk_start_a = 1; cfg_stride_a = 2'd1; cfg_ow_a = 8'd2; cfg_ohg_a = 8'd1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #2;
            blk_start_a = 0;
        end
        check("t5_in_shift", valid_a, 1);
        rst_n_a = 0;
        @(posedge clk); #2;
        rst_n_a = 1;
        check_reset_a();
        rdq_a.delete(); bq_a.delete(); fifo_pend_a = 0;
        run_block(0, 1, 2, 1, 0, 0, 0, 0, lat);
        check("t5_rerun_latency", lat, 14);

        // T6: KSIZE=5, POY=4, stride 3, ow 5
        r0 = reads_b; b0 = beats_b;
        run_block(1, 3, 5, 1, 0, 0, 0, 0, lat);
        check("t6_latency", lat, 42);
        check("t6_reads", reads_b - r0, 5);
        check("t6_beats", beats_b - b0, 25);

        // Randomised blocks with random back-pressure
        for (int i = 0; i < 24; i++) begin
            run_block(0, int'($urandom % 4), int'($urandom % 5), int'($urandom % 4), 1, 0, 0, 0, lat);
        end
        for (int i = 0; i < 6; i++) begin
            run_block(1, int'($urandom % 4), int'($urandom % 7), int'($urandom % 3), 1, 0, 0, 0, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
